// File: rtl/bcd_conv_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_conv_pkg;

    // Output digit code selection
    typedef enum logic [1:0] {
        CODE_8421 = 2'b00,
        CODE_5421 = 2'b01,
        CODE_XS3  = 2'b10,
        CODE_RSVD = 2'b11
    } code_t;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        ENCODE = 2'b10
    } state_t;

    // Pattern shown on every digit when the result is unusable
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    // Map a plain decimal digit (0..9) into the selected output code
    function automatic logic [3:0] code_map(input logic [3:0] d, input code_t code);
        logic [3:0] q;
        q = DIGIT_INVALID;
        case (code)
            CODE_8421: q = d;
            CODE_5421: q = (d < 4'd5) ? d : d + 4'd3;
            CODE_XS3:  q = d + 4'd3;
            default:   q = DIGIT_INVALID;
        endcase
        return q;
    endfunction

    // 10^n, used to derive the overflow limit at elaboration time
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One double-dabble correction step: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_step
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Combinational add-3 correction
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter: BIN_W shift-add-3 cycles followed by one
// encode cycle that maps every digit to 8421, 5421 or excess-3.
module bcd_seq_conv
    import bcd_conv_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [1:0]            code_sel,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  err
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    // Comparison width wide enough for both the input and 10^8-1
    localparam int CMP_W = (BIN_W > 32) ? BIN_W : 32;
    localparam logic [CMP_W-1:0] OVF_LIMIT = CMP_W'(pow10(DIGITS) - 64'd1);

    state_t                state_reg;
    logic [BIN_W-1:0]      bin_reg;
    logic [4*DIGITS-1:0]   digits_reg;
    logic [CNT_W-1:0]      cnt_reg;
    code_t                 code_reg;
    logic                  ovf_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic [4*DIGITS-1:0]   bcd_out_reg;

    logic [4*DIGITS-1:0]   adj_digits;
    logic [4*DIGITS-1:0]   coded_digits;

    // Per-digit add-3 correction and output code mapping
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_step u_step (
                .digit    (digits_reg[4*gi +: 4]),
                .adjusted (adj_digits[4*gi +: 4])
            );
            assign coded_digits[4*gi +: 4] = code_map(digits_reg[4*gi +: 4], code_reg);
        end
    endgenerate

    // Control FSM together with the shift datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bin_reg     <= '0;
            digits_reg  <= '0;
            cnt_reg     <= '0;
            code_reg    <= CODE_8421;
            ovf_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            bcd_out_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bin_reg    <= bin_in;
                        code_reg   <= code_t'(code_sel);
                        // Overflow is decided up front; the shift still runs full length
                        ovf_reg    <= (CMP_W'(bin_in) > OVF_LIMIT);
                        digits_reg <= '0;
                        cnt_reg    <= CNT_W'(BIN_W);
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits_reg <= {adj_digits[4*DIGITS-2:0], bin_reg[BIN_W-1]};
                    bin_reg    <= {bin_reg[BIN_W-2:0], 1'b0};
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (ovf_reg || (code_reg == CODE_RSVD)) begin
                        bcd_out_reg <= {DIGITS{DIGIT_INVALID}};
                        err_reg     <= 1'b1;
                    end else begin
                        bcd_out_reg <= coded_digits;
                        err_reg     <= 1'b0;
                    end
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bcd_out = bcd_out_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: directed and random conversions on a 3-digit and a
// 2-digit instance, checked against an arithmetic decimal reference model.
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start1 = 1'b0;
    logic [7:0]  bin1 = '0;
    logic [1:0]  code1 = '0;
    logic        busy1, done1, err1;
    logic [11:0] bcd1;

    logic        start2 = 1'b0;
    logic [7:0]  bin2 = '0;
    logic [1:0]  code2 = '0;
    logic        busy2, done2, err2;
    logic [7:0]  bcd2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_seq_conv #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .start(start1), .bin_in(bin1), .code_sel(code1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .err(err1)
    );

    bcd_seq_conv #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin2), .code_sel(code2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: split by /10 and %10, then apply the code rules
    function automatic logic [31:0] ref_conv(input int b, input int c, input int nd, output logic e);
        logic [31:0] r;
        int v, d, lim;
        r = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (c == 3 || b > lim - 1) begin
            for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'hF;
            e = 1'b1;
        end else begin
            v = b;
            for (int i = 0; i < nd; i++) begin
                d = v % 10;
                v = v / 10;
                if (c == 1) d = (d < 5) ? d : d + 3;
                else if (c == 2) d = d + 3;
                r[4*i +: 4] = 4'(d);
            end
            e = 1'b0;
        end
        return r;
    endfunction

    // One conversion; call at a negedge. Ends at the negedge where done is seen,
    // so a following call asserts start in the done cycle.
    // poke_at >= 0 pulses start with junk data at that cycle while busy.
    task automatic conv(input int which, input int b, input int c, input int poke_at);
        int idx, busy_cnt;
        logic e;
        logic [31:0] exp, got;
        logic cur_done, cur_busy;
        exp = ref_conv(b, c, (which == 2) ? 2 : 3, e);
        if (which == 2) begin bin2 = 8'(b); code2 = 2'(c); start2 = 1'b1; end
        else begin bin1 = 8'(b); code1 = 2'(c); start1 = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        bin1 = 8'($urandom); bin2 = 8'($urandom);
        code1 = 2'($urandom); code2 = 2'($urandom);
        idx = 0;
        busy_cnt = 0;
        cur_done = (which == 2) ? done2 : done1;
        while (!cur_done && idx < 30) begin
            cur_busy = (which == 2) ? busy2 : busy1;
            if (cur_busy) busy_cnt++;
            if (idx == poke_at) begin
                if (which == 2) start2 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0; start2 = 1'b0;
            end
            @(negedge clk);
            idx++;
            cur_done = (which == 2) ? done2 : done1;
        end
        start1 = 1'b0; start2 = 1'b0;
        got = (which == 2) ? {24'b0, bcd2} : {20'b0, bcd1};
        check("latency", 32'(idx), 32'd9);
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("bcd_out", got, exp);
        check("err", {31'b0, (which == 2) ? err2 : err1}, {31'b0, e});
        $display("[TB] dut%0d bin=%0d code=%0d -> bcd=%0h err=%0b (exp %0h/%0b) lat=%0d",
                 which, b, c, got, (which == 2) ? err2 : err1, exp, e, idx);
    endtask

    // Watch for a number of cycles and return how many done pulses appeared
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done1) n++;
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy1}, 32'd0);
        check("rst_done", {31'b0, done1}, 32'd0);
        check("rst_err", {31'b0, err1}, 32'd0);
        check("rst_bcd", {20'b0, bcd1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed conversions, back to back (start lands in each done cycle)
        conv(1, 137, 0, -1);
        conv(1, 137, 1, -1);
        conv(1, 137, 2, -1);
        conv(1, 255, 2, -1);
        conv(1, 0, 2, -1);
        conv(1, 42, 3, -1);
        conv(1, 255, 0, -1);
        @(negedge clk);
        check("done_one_pulse", {31'b0, done1}, 32'd0);

        // Two-digit instance: overflow boundary
        conv(2, 100, 0, -1);
        conv(2, 99, 0, -1);
        conv(2, 255, 1, -1);
        @(negedge clk);

        // start pulse while busy is ignored: exactly one done
        conv(1, 73, 0, 3);
        count_dones(15, n);
        check("busy_start_ignored", 32'(n), 32'd0);

        // Reset in the 4th SHIFT cycle aborts and clears outputs
        bin1 = 8'd200; code1 = 2'd0; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy1}, 32'd0);
        check("abort_done", {31'b0, done1}, 32'd0);
        check("abort_bcd", {20'b0, bcd1}, 32'd0);
        check("abort_err", {31'b0, err1}, 32'd0);
        count_dones(15, n);
        check("abort_no_done", 32'(n), 32'd0);
        $display("[TB] reset abort checked, dones after abort=%0d", n);
        conv(1, 137, 0, -1);

        // Randomized conversions on both instances
        for (int i = 0; i < 16; i++) begin
            conv(1, int'($urandom_range(255)), int'($urandom_range(3)), -1);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            conv(2, int'($urandom_range(255)), int'($urandom_range(3)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
